// File: rtl/ren_issue_ctrl.sv
// Read-enable issue stage for the cascaded ren chain: accepts requests, emits
// spaced one-cycle io_ren pulses and throttles on an in-flight credit count.
module ren_issue_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int GAP             = 2,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic             io_flush,
    input  logic             io_done,
    output logic             io_ren,
    output logic [CNT_W-1:0] io_outstanding,
    output logic             io_busy,
    output logic             io_underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       GAP_LOAD = 4'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [3:0]       gap_r;
    logic [3:0]       gap_s;
    logic             ren_r;
    logic             ren_s;
    logic             uf_r;
    logic             uf_s;
    logic             busy_r;
    logic             busy_s;
    logic             ready_s;
    logic             accept_s;
    logic             done_eff_s;

    // Handshake decode: ready is a function of state, flush and reset only.
    always_comb begin
        ready_s    = 1'b0;
        accept_s   = 1'b0;
        done_eff_s = 1'b0;
        if ((state_r == ST_IDLE) && !io_flush && reset) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s   = io_req_valid & ready_s;
        // A completion with nothing in flight is dropped and only flagged.
        done_eff_s = io_done & (cnt_r != CNT_ZERO);
    end

    // Next values of the credit counter, gap counter, pulse and error flag.
    always_comb begin
        cnt_s  = cnt_r;
        gap_s  = gap_r;
        uf_s   = uf_r;
        ren_s  = 1'b0;
        busy_s = 1'b0;
        if (io_flush) begin
            cnt_s = CNT_ZERO;
            gap_s = 4'd0;
            uf_s  = 1'b0;
            ren_s = 1'b0;
        end else begin
            ren_s = accept_s;
            if (accept_s && !done_eff_s) begin
                cnt_s = cnt_r + CNT_ONE;
            end else if (!accept_s && done_eff_s) begin
                cnt_s = cnt_r - CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end
            if (accept_s) begin
                gap_s = GAP_LOAD;
            end else if (gap_r != 4'd0) begin
                gap_s = gap_r - 4'd1;
            end else begin
                gap_s = gap_r;
            end
            if (io_done && (cnt_r == CNT_ZERO)) begin
                uf_s = 1'b1;
            end else begin
                uf_s = uf_r;
            end
        end
        busy_s = (cnt_s != CNT_ZERO) | (gap_s != 4'd0);
    end

    // Issue FSM next-state; decisions use the post-edge count so a same-cycle
    // completion is already taken into account.
    always_comb begin
        state_s = state_r;
        if (io_flush) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (GAP_LOAD != 4'd0) begin
                            state_s = ST_GAP;
                        end else if (cnt_s == MAX_CNT) begin
                            state_s = ST_FULL;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    // Leaving when the counter steps 1 -> 0 makes the next
                    // accept land exactly GAP+1 cycles after the previous one.
                    if (gap_r <= 4'd1) begin
                        if (cnt_s == MAX_CNT) begin
                            state_s = ST_FULL;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                ST_FULL: begin
                    if (cnt_s < MAX_CNT) begin
                        if (gap_s != 4'd0) begin
                            state_s = ST_GAP;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            gap_r   <= 4'd0;
            ren_r   <= 1'b0;
            uf_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            gap_r   <= gap_s;
            ren_r   <= ren_s;
            uf_r    <= uf_s;
            busy_r  <= busy_s;
        end
    end

    assign io_req_ready   = ready_s;
    assign io_ren         = ren_r;
    assign io_outstanding = cnt_r;
    assign io_busy        = busy_r;
    assign io_underflow   = uf_r;

endmodule

// File: tb/tb_ren_issue_ctrl.sv
// Table-driven bench for ren_issue_ctrl: one instance with GAP=2, one with GAP=0.
module tb_ren_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_a, flush_a, done_a, rdy_a, ren_a, busy_a, uf_a;
    logic [2:0] cnt_a;
    logic       valid_b, flush_b, done_b, rdy_b, ren_b, busy_b, uf_b;
    logic [2:0] cnt_b;

    ren_issue_ctrl #(.MAX_OUTSTANDING(4), .GAP(2), .CNT_W(3)) u_gap2 (
        .clk(clk), .reset(reset),
        .io_req_valid(valid_a), .io_req_ready(rdy_a),
        .io_flush(flush_a), .io_done(done_a),
        .io_ren(ren_a), .io_outstanding(cnt_a),
        .io_busy(busy_a), .io_underflow(uf_a)
    );

    ren_issue_ctrl #(.MAX_OUTSTANDING(4), .GAP(0), .CNT_W(3)) u_gap0 (
        .clk(clk), .reset(reset),
        .io_req_valid(valid_b), .io_req_ready(rdy_b),
        .io_flush(flush_b), .io_done(done_b),
        .io_ren(ren_b), .io_outstanding(cnt_b),
        .io_busy(busy_b), .io_underflow(uf_b)
    );

    always #5 clk = ~clk;

    // in  = {sel(0:GAP2 1:GAP0), valid, flush, done}
    // exp = {ready, ren, outstanding[2:0], busy, underflow}, observed in the same cycle
    typedef struct {
        logic [3:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] sb[$];
    int         n_vec  = 0;
    int         n_miss = 0;

    function automatic vec_t mk(input logic [3:0] in, input logic [6:0] exp);
        vec_t t;
        t.in  = in;
        t.exp = exp;
        return t;
    endfunction

    function automatic logic [6:0] obs(input logic sel);
        if (sel) return {rdy_b, ren_b, cnt_b, busy_b, uf_b};
        return {rdy_a, ren_a, cnt_a, busy_a, uf_a};
    endfunction

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: rdy/ren/cnt/busy/uf got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        logic [6:0] e;
        @(negedge clk);
        valid_a = (v.in[3] == 1'b0) ? v.in[2] : 1'b0;
        flush_a = (v.in[3] == 1'b0) ? v.in[1] : 1'b0;
        done_a  = (v.in[3] == 1'b0) ? v.in[0] : 1'b0;
        valid_b = (v.in[3] == 1'b1) ? v.in[2] : 1'b0;
        flush_b = (v.in[3] == 1'b1) ? v.in[1] : 1'b0;
        done_b  = (v.in[3] == 1'b1) ? v.in[0] : 1'b0;
        sb.push_back(v.exp);
        #3;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = sb.pop_front();
            cmp($sformatf("vec%0d", idx), obs(v.in[3]), e);
        end
    endtask

    initial begin
        valid_a = 1'b0; flush_a = 1'b0; done_a = 1'b0;
        valid_b = 1'b0; flush_b = 1'b0; done_b = 1'b0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #1;
        cmp("reset_gap2", obs(1'b0), 7'b0_0_000_0_0);
        cmp("reset_gap0", obs(1'b1), 7'b0_0_000_0_0);

        // GAP=2: fill to four in flight, pulses 3 cycles apart, then hold in FULL
        tbl.push_back(mk(4'b0100, 7'b1_0_000_0_0));
        for (int k = 1; k <= 3; k++) begin
            tbl.push_back(mk(4'b0100, {2'b01, 3'(k), 2'b10}));
            tbl.push_back(mk(4'b0100, {2'b00, 3'(k), 2'b10}));
            tbl.push_back(mk(4'b0100, {2'b10, 3'(k), 2'b10}));
        end
        tbl.push_back(mk(4'b0100, 7'b0_1_100_1_0));
        tbl.push_back(mk(4'b0100, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b0100, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b0100, 7'b0_0_100_1_0));
        // one completion from FULL re-opens the handshake next cycle
        tbl.push_back(mk(4'b0001, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b0100, 7'b1_0_011_1_0));
        tbl.push_back(mk(4'b0000, 7'b0_1_100_1_0));
        tbl.push_back(mk(4'b0000, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b0110, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b0000, 7'b1_0_000_0_0));
        // underflow is sticky until a flush
        tbl.push_back(mk(4'b0001, 7'b1_0_000_0_0));
        tbl.push_back(mk(4'b0000, 7'b1_0_000_0_1));
        tbl.push_back(mk(4'b0000, 7'b1_0_000_0_1));
        tbl.push_back(mk(4'b0010, 7'b0_0_000_0_1));
        // refill to three, then flush with a request present mid-gap
        tbl.push_back(mk(4'b0100, 7'b1_0_000_0_0));
        for (int k = 1; k <= 2; k++) begin
            tbl.push_back(mk(4'b0100, {2'b01, 3'(k), 2'b10}));
            tbl.push_back(mk(4'b0100, {2'b00, 3'(k), 2'b10}));
            tbl.push_back(mk(4'b0100, {2'b10, 3'(k), 2'b10}));
        end
        tbl.push_back(mk(4'b0100, 7'b0_1_011_1_0));
        tbl.push_back(mk(4'b0110, 7'b0_0_011_1_0));
        tbl.push_back(mk(4'b0000, 7'b1_0_000_0_0));
        // flush wins over a same-cycle done at zero: no underflow
        tbl.push_back(mk(4'b0011, 7'b0_0_000_0_0));
        tbl.push_back(mk(4'b0000, 7'b1_0_000_0_0));

        // GAP=0: accept and done every cycle keep the count at 1
        tbl.push_back(mk(4'b1100, 7'b1_0_000_0_0));
        for (int k = 0; k < 6; k++) tbl.push_back(mk(4'b1101, 7'b1_1_001_1_0));
        tbl.push_back(mk(4'b1001, 7'b1_1_001_1_0));
        // GAP=0: back-to-back fill reaches FULL, one done reopens, flush clears
        tbl.push_back(mk(4'b1100, 7'b1_0_000_0_0));
        tbl.push_back(mk(4'b1100, 7'b1_1_001_1_0));
        tbl.push_back(mk(4'b1100, 7'b1_1_010_1_0));
        tbl.push_back(mk(4'b1100, 7'b1_1_011_1_0));
        tbl.push_back(mk(4'b1100, 7'b0_1_100_1_0));
        tbl.push_back(mk(4'b1100, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b1101, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b1100, 7'b1_0_011_1_0));
        tbl.push_back(mk(4'b1000, 7'b0_1_100_1_0));
        tbl.push_back(mk(4'b1010, 7'b0_0_100_1_0));
        tbl.push_back(mk(4'b1000, 7'b1_0_000_0_0));

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // asynchronous reset while a pulse is on the output
        @(negedge clk);
        valid_a = 1'b1;
        @(posedge clk);
        #1 valid_a = 1'b0;
        cmp("async_pre", obs(1'b0), 7'b0_1_001_1_0);
        #2 reset = 1'b0;
        #1 cmp("async_now", obs(1'b0), 7'b0_0_000_0_0);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3 cmp($sformatf("async_post%0d", k), obs(1'b0), 7'b1_0_000_0_0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ren_issue_ctrl.md
Name:
ren_issue_ctrl

Overview:
Upstream read-enable issue stage for the cascaded ren pass-through chain.
- Accepts read requests over a valid/ready handshake.
- Emits one-cycle registered io_ren pulses into the chain's io_in_ren, with a configurable minimum spacing.
- Tracks reads in flight with a credit counter. The chain's OR-reduced io_result is returned as the completion strobe io_done.
- Throttles issue so that no more than MAX_OUTSTANDING reads are in flight.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads in flight; one per chain stage; legal range 1..7.
- GAP, 2, idle cycles forced between consecutive accepts; legal range 0..15.
- CNT_W, 3, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- io_req_valid, input, 1, request present.
- io_req_ready, output, 1, request may be accepted this cycle.
- io_flush, input, 1, synchronous abort; clears all in-flight state.
- io_done, input, 1, one-cycle completion strobe from downstream.
- io_ren, output, 1, registered read-enable pulse, driven to the chain's io_in_ren.
- io_outstanding, output, CNT_W, current in-flight count.
- io_busy, output, 1, high when io_outstanding != 0 or the gap counter is nonzero.
- io_underflow, output, 1, sticky error flag: io_done received with zero outstanding.

Behaviour:
Reset
- reset low forces, asynchronously:
  - state = IDLE
  - io_ren = 0
  - outstanding = 0
  - gap counter = 0
  - io_underflow = 0
  - io_req_ready = 0 (held while reset is low)
- Reset asserted mid-operation discards all in-flight state; no io_ren pulse follows deassertion.

Handshake
- accept = io_req_valid & io_req_ready.
- io_req_ready = (state == IDLE) & !io_flush & reset.
- io_req_ready is combinational from state. It does not depend on io_req_valid.

States
- IDLE: ready is asserted.
  - On accept: go to GAP if GAP > 0; else go to FULL if the new outstanding == MAX_OUTSTANDING; else stay in IDLE.
- GAP: the gap counter is loaded with GAP on the accept edge and decrements each cycle.
  - When the counter reaches 0: go to FULL if outstanding == MAX_OUTSTANDING, else go to IDLE.
- FULL: entered when outstanding == MAX_OUTSTANDING.
  - Leave to IDLE on the edge where io_done lowers the count below MAX_OUTSTANDING.
  - If the gap counter is still nonzero at that point, go to GAP instead.

Latency and spacing
- Accept in cycle t gives io_ren = 1 in cycle t+1 only, for exactly one cycle.
- With GAP = g, the earliest next accept is cycle t+g+1, so io_ren pulses are spaced g+1 cycles apart.

Outstanding counter
- next = outstanding + accept - (io_done & outstanding != 0).
- Accept and io_done in the same cycle: net change 0, and the state stays out of FULL.
- The count never exceeds MAX_OUTSTANDING and never wraps below 0.
- io_done while outstanding == 0: ignored, and io_underflow is set. io_underflow clears only on reset or io_flush.

Flush
- io_flush has priority over accept and io_done.
- On the next edge: outstanding = 0, gap counter = 0, state = IDLE, io_underflow = 0, io_ren = 0.
- A request presented during the flush cycle is not accepted.

Test Plan:
1. Reset release with io_req_valid = 1 held, GAP = 2 → io_req_ready = 1 in the first cycle after reset; io_ren pulses in cycles 1, 4, 7, 10; io_outstanding goes 1, 2, 3, 4; io_req_ready stays 0 after the 4th accept.
2. Chain full (outstanding = 4), pulse io_done once → outstanding = 3 on the next edge; io_req_ready = 1 in the following cycle; the next io_ren follows one cycle after that accept.
3. GAP = 0 with io_req_valid and io_done both high every cycle starting from outstanding = 1 → io_ren is high every cycle; io_outstanding stays at 1; the state never reaches FULL.
4. io_done with outstanding = 0 → io_outstanding stays 0 and io_underflow = 1 and remains set. A later io_flush clears io_underflow to 0.
5. io_flush together with io_req_valid at outstanding = 3, mid-GAP → no accept and no io_ren; next cycle outstanding = 0, io_busy = 0, io_req_ready = 1.
6. reset driven low asynchronously between clock edges while io_ren = 1 → io_ren, io_outstanding and io_req_ready go to 0 immediately; after release, no stale io_ren pulse appears.
